// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light monitor: phases, one-hot bus codes,
// monitor FSM states and phase-order helpers.
package traffic_pkg;

   localparam logic [1:0] PH_RED  = 2'b00;
   localparam logic [1:0] PH_GRN  = 2'b01;
   localparam logic [1:0] PH_YEL  = 2'b10;
   localparam logic [1:0] PH_NONE = 2'b11;

   localparam logic [2:0] LT_RED = 3'b001;
   localparam logic [2:0] LT_GRN = 3'b010;
   localparam logic [2:0] LT_YEL = 3'b100;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'b00,
      ST_TRK_R = 2'b01,
      ST_TRK_G = 2'b10,
      ST_TRK_Y = 2'b11
   } mon_state_t;

   function automatic logic [1:0] next_phase(input logic [1:0] ph);
      logic [1:0] nx;
      case (ph)
         PH_RED:  nx = PH_GRN;
         PH_GRN:  nx = PH_YEL;
         PH_YEL:  nx = PH_RED;
         default: nx = PH_NONE;
      endcase
      return nx;
   endfunction

   function automatic mon_state_t trk_state(input logic [1:0] ph);
      mon_state_t st;
      case (ph)
         PH_RED:  st = ST_TRK_R;
         PH_GRN:  st = ST_TRK_G;
         PH_YEL:  st = ST_TRK_Y;
         default: st = ST_SYNC;
      endcase
      return st;
   endfunction

   function automatic logic [1:0] state_phase(input mon_state_t st);
      logic [1:0] ph;
      case (st)
         ST_TRK_R: ph = PH_RED;
         ST_TRK_G: ph = PH_GRN;
         ST_TRK_Y: ph = PH_YEL;
         default:  ph = PH_NONE;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/light_code_decode.sv
// Combinational decode of the 3-bit light bus into a legality flag and phase.
module light_code_decode
   import traffic_pkg::*;
(
   input  logic [2:0] code,
   output logic       legal,
   output logic [1:0] phase
);

   // One-hot code to phase; everything else (000 included) is illegal
   always_comb begin
      legal = 1'b0;
      phase = PH_NONE;
      case (code)
         LT_RED: begin
            legal = 1'b1;
            phase = PH_RED;
         end
         LT_GRN: begin
            legal = 1'b1;
            phase = PH_GRN;
         end
         LT_YEL: begin
            legal = 1'b1;
            phase = PH_YEL;
         end
         default: begin
            legal = 1'b0;
            phase = PH_NONE;
         end
      endcase
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side watchdog for the one-hot traffic light bus: tracks the phase,
// measures phase dwell and raises sticky code / order / dwell violation flags.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int RED_MIN = 2,
   parameter int RED_MAX = 8,
   parameter int GRN_MIN = 2,
   parameter int GRN_MAX = 8,
   parameter int YEL_MIN = 2,
   parameter int YEL_MAX = 12
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       light,
   input  logic             clr_err,
   output logic [1:0]       phase,
   output logic             phase_valid,
   output logic [CNT_W-1:0] dwell,
   output logic [1:0]       dwell_phase,
   output logic             dwell_valid,
   output logic             err_code,
   output logic             err_seq,
   output logic             err_dwell,
   output logic [7:0]       err_count
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

   logic [2:0]       light_q_r;
   logic             lq_vld_r;
   logic             illeg_prev_r;
   mon_state_t       state_r;
   mon_state_t       state_nx;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             overrun_r;
   logic             overrun_nx;
   logic             sync_entry_r;
   logic             sync_entry_nx;

   logic             legal_s;
   logic [1:0]       code_ph_s;
   logic [1:0]       cur_ph_s;
   logic [CNT_W-1:0] min_s;
   logic [CNT_W-1:0] over_s;
   logic             illegal_s;
   logic             enter_s;
   logic             hold_s;
   logic             change_s;
   logic             code_ev_s;
   logic             seq_ev_s;
   logic             over_ev_s;
   logic             exit_ev_s;
   logic             any_ev_s;

   logic [1:0]       phase_nx;
   logic             phase_valid_nx;
   logic [CNT_W-1:0] dwell_nx;
   logic [1:0]       dwell_phase_nx;
   logic             dwell_valid_nx;
   logic             err_code_nx;
   logic             err_seq_nx;
   logic             err_dwell_nx;
   logic [7:0]       err_count_nx;

   light_code_decode u_decode (
      .code  (light_q_r),
      .legal (legal_s),
      .phase (code_ph_s)
   );

   // Input capture; lq_vld_r keeps the reset value of light_q out of the checks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         light_q_r    <= 3'b000;
         lq_vld_r     <= 1'b0;
         illeg_prev_r <= 1'b0;
      end else begin
         light_q_r    <= light;
         lq_vld_r     <= 1'b1;
         illeg_prev_r <= illegal_s;
      end
   end

   assign cur_ph_s  = state_phase(state_r);
   assign illegal_s = lq_vld_r & ~legal_s;
   assign enter_s   = lq_vld_r & legal_s & (state_r == ST_SYNC);
   assign hold_s    = lq_vld_r & legal_s & (state_r != ST_SYNC) & (code_ph_s == cur_ph_s);
   assign change_s  = lq_vld_r & legal_s & (state_r != ST_SYNC) & (code_ph_s != cur_ph_s);
   assign cnt_inc_s = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_ONE;

   // Dwell window of the phase currently being tracked; over_s is MAX+1
   always_comb begin
      min_s  = CNT_ZERO;
      over_s = CNT_SAT;
      case (state_r)
         ST_TRK_R: begin
            min_s  = CNT_W'(RED_MIN);
            over_s = CNT_W'(RED_MAX + 1);
         end
         ST_TRK_G: begin
            min_s  = CNT_W'(GRN_MIN);
            over_s = CNT_W'(GRN_MAX + 1);
         end
         ST_TRK_Y: begin
            min_s  = CNT_W'(YEL_MIN);
            over_s = CNT_W'(YEL_MAX + 1);
         end
         default: begin
            min_s  = CNT_ZERO;
            over_s = CNT_SAT;
         end
      endcase
   end

   // A held illegal code is one event, not one per cycle
   assign code_ev_s = illegal_s & ~illeg_prev_r;
   assign seq_ev_s  = change_s & (code_ph_s != next_phase(cur_ph_s));
   assign over_ev_s = hold_s & (cnt_inc_s == over_s) & ~overrun_r;
   assign exit_ev_s = change_s & ~sync_entry_r &
                      ((cnt_r < min_s) | ((cnt_r >= over_s) & ~overrun_r));
   assign any_ev_s  = code_ev_s | seq_ev_s | over_ev_s | exit_ev_s;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_SYNC;
      end else begin
         state_r <= state_nx;
      end
   end

   // FSM next state: illegal codes force resync, any legal change is followed
   always_comb begin
      state_nx = state_r;
      if (illegal_s) begin
         state_nx = ST_SYNC;
      end else if (enter_s || change_s) begin
         state_nx = trk_state(code_ph_s);
      end else begin
         state_nx = state_r;
      end
   end

   // FSM outputs and datapath next values
   always_comb begin
      cnt_nx        = cnt_r;
      overrun_nx    = overrun_r;
      sync_entry_nx = sync_entry_r;
      if (illegal_s) begin
         cnt_nx        = CNT_ZERO;
         overrun_nx    = 1'b0;
         sync_entry_nx = 1'b0;
      end else if (enter_s) begin
         cnt_nx        = CNT_ONE;
         overrun_nx    = 1'b0;
         sync_entry_nx = 1'b1;
      end else if (change_s) begin
         cnt_nx        = CNT_ONE;
         overrun_nx    = 1'b0;
         sync_entry_nx = 1'b0;
      end else if (hold_s) begin
         cnt_nx        = cnt_inc_s;
         overrun_nx    = overrun_r | over_ev_s;
         sync_entry_nx = sync_entry_r;
      end else begin
         cnt_nx        = cnt_r;
         overrun_nx    = overrun_r;
         sync_entry_nx = sync_entry_r;
      end

      phase_nx       = state_phase(state_nx);
      phase_valid_nx = (state_nx != ST_SYNC);

      dwell_valid_nx = change_s & ~sync_entry_r;
      if (dwell_valid_nx) begin
         dwell_nx       = cnt_r;
         dwell_phase_nx = cur_ph_s;
      end else begin
         dwell_nx       = dwell;
         dwell_phase_nx = dwell_phase;
      end

      // A violation in the clearing cycle survives the clear
      if (clr_err) begin
         err_code_nx  = code_ev_s;
         err_seq_nx   = seq_ev_s;
         err_dwell_nx = over_ev_s | exit_ev_s;
         err_count_nx = any_ev_s ? 8'd1 : 8'd0;
      end else begin
         err_code_nx  = err_code | code_ev_s;
         err_seq_nx   = err_seq | seq_ev_s;
         err_dwell_nx = err_dwell | over_ev_s | exit_ev_s;
         if (any_ev_s && (err_count != 8'd255)) begin
            err_count_nx = err_count + 8'd1;
         end else begin
            err_count_nx = err_count;
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r        <= CNT_ZERO;
         overrun_r    <= 1'b0;
         sync_entry_r <= 1'b0;
         phase        <= PH_NONE;
         phase_valid  <= 1'b0;
         dwell        <= CNT_ZERO;
         dwell_phase  <= 2'b00;
         dwell_valid  <= 1'b0;
         err_code     <= 1'b0;
         err_seq      <= 1'b0;
         err_dwell    <= 1'b0;
         err_count    <= 8'd0;
      end else begin
         cnt_r        <= cnt_nx;
         overrun_r    <= overrun_nx;
         sync_entry_r <= sync_entry_nx;
         phase        <= phase_nx;
         phase_valid  <= phase_valid_nx;
         dwell        <= dwell_nx;
         dwell_phase  <= dwell_phase_nx;
         dwell_valid  <= dwell_valid_nx;
         err_code     <= err_code_nx;
         err_seq      <= err_seq_nx;
         err_dwell    <= err_dwell_nx;
         err_count    <= err_count_nx;
      end
   end

endmodule
